serial_addsub: RTL
==================

# serial_addsub

Bit-serial adder/subtractor that computes a WIDTH-bit two's-complement sum or difference one bit per clock. It keeps a single full-adder slice in time and rebuilds the result word internally, LSB first. It returns the same result word and overflow flags (S, OVU, OVS) as the combinational add/subtract slice array, behind a start/done handshake. It sits in the arithmetic datapath where area matters more than latency.

## Interface
- WIDTH, default 4: operand and result width in bits. Legal range is WIDTH ≥ 2.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- START  in  1  request a new operation. Sampled only in IDLE.
- A  in  WIDTH  first operand. Captured on the accepted START edge.
- B  in  WIDTH  second operand. Captured on the accepted START edge.
- MODE  in  1  operation select: 0 = A+B, 1 = A−B. Captured with A and B.
- S  out  WIDTH  result word. Registered and held until the next completion.
- OVU  out  1  unsigned flag: carry-out for add, borrow for subtract.
- OVS  out  1  signed two's-complement overflow.
- BUSY  out  1  high while the FSM is in RUN.
- DONE  out  1  one-cycle pulse when S, OVU and OVS have just been updated.

## Operation
- FSM states: IDLE, RUN, FIN.
- IDLE, START=1 at an edge:
  - latch opa = A;
  - latch opb = B when MODE=0, or ~B when MODE=1;
  - latch mode = MODE;
  - set carry = MODE;
  - set bit counter = 0;
  - move to RUN.
- IDLE, START=0: stay in IDLE.
- RUN, each edge:
  - sum bit = opa[0] ^ opb[0] ^ carry;
  - shift the sum bit into the result shift register from the MSB side (LSB-first accumulation);
  - shift opa and opb right by one;
  - carry = majority(opa[0], opb[0], carry);
  - counter increments.
- On the edge that processes bit WIDTH−1, the counter reaches WIDTH−1:
  - S is loaded with the completed word;
  - OVU = carry_out XOR mode. This equals carry-out for add and NOT carry-out (borrow) for subtract;
  - OVS = carry into the MSB XOR carry out of the MSB. The carry into the MSB is the carry value held before the final bit;
  - the FSM moves to FIN.
- FIN: DONE=1 for exactly one cycle, then the FSM returns to IDLE unconditionally.
- START while in RUN or FIN is ignored and is not queued. A, B and MODE changes after the accepted edge have no effect.
- Arithmetic is modulo 2^WIDTH. Subtraction is A + ~B + 1.
- The counter width is clog2(WIDTH). There is no wrap beyond WIDTH−1 because the FSM leaves RUN at that point.

## Timing
- Reset value of every output is 0: S=0, OVU=0, OVS=0, BUSY=0, DONE=0. FSM is IDLE.
- rst asserted at any time, including mid-RUN or in FIN, clears all state immediately. The in-flight operation is aborted and no DONE is produced. The operation resumes only after a new START once rst is low.
- Latency: take the accepted START edge as edge 0.
  - BUSY is high from after edge 0 until after edge WIDTH.
  - S, OVU, OVS and DONE become valid after edge WIDTH.
  - DONE falls after edge WIDTH+1.
- Throughput: one operation per WIDTH+2 cycles. The earliest next START is accepted at edge WIDTH+2, which is the first edge back in IDLE.
- START held high continuously gives back-to-back operations, each starting at the first IDLE edge.
- S, OVU and OVS are stable outside the completion edge. They are never driven with partial results.

## Test plan
- Reset: assert rst mid-RUN (WIDTH=4, A=0101, B=0001, rst at edge 2) -> all outputs 0 at once, no DONE pulse, BUSY low. Then START after rst=0 -> normal completion.
- Add: MODE=0, A=0101, B=0001 -> DONE after edge 4, S=0110, OVU=0, OVS=0. BUSY high for exactly 4 cycles.
- Subtract with signed overflow: MODE=1, A=1011, B=0101 -> S=0110, OVU=0, OVS=1.
- Add boundaries:
  - MODE=0, A=0111, B=0001 -> S=1000, OVU=0, OVS=1.
  - MODE=0, A=1111, B=0001 -> S=0000, OVU=1, OVS=0.
- Borrow: MODE=1, A=0001, B=0010 -> S=1111, OVU=1, OVS=0.
- Handshake:
  - a second START pulse mid-RUN is ignored, with exactly one DONE;
  - START held high gives DONE every 6 cycles with WIDTH=4;
  - A and B changed during RUN do not alter S.

Source files
------------

// File: rtl/serial_addsub.sv
// Bit-serial two's-complement adder/subtractor.
// One full-adder slice is reused over WIDTH cycles; the result word is rebuilt
// LSB first in a shift register and published with the overflow flags on completion.
module serial_addsub #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             MODE,
    output logic [WIDTH-1:0] S,
    output logic             OVU,
    output logic             OVS,
    output logic             BUSY,
    output logic             DONE
);

    localparam int unsigned    CntW    = $clog2(WIDTH);
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StFin
    } state_e;

    state_e state_q, state_d;

    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             mode_q, mode_d;
    logic             carry_q, carry_d;
    logic             ovu_q, ovu_d;
    logic             ovs_q, ovs_d;

    logic             sum_bit;
    logic             carry_nxt;
    logic             accept;
    logic             last_bit;

    assign accept    = (state_q == StIdle) && START;
    assign last_bit  = (state_q == StRun) && (cnt_q == LastCnt);
    assign sum_bit   = opa_q[0] ^ opb_q[0] ^ carry_q;
    assign carry_nxt = (opa_q[0] & opb_q[0]) | (opa_q[0] & carry_q) | (opb_q[0] & carry_q);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: FIN always returns to IDLE, so START is never queued.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (START) state_d = StRun;
            StRun:   if (cnt_q == LastCnt) state_d = StFin;
            StFin:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Status outputs decoded from the current state.
    always_comb begin
        BUSY = (state_q == StRun);
        DONE = (state_q == StFin);
    end

    // Datapath next-state: operand capture, one slice per cycle, result publish on last bit.
    always_comb begin
        opa_d   = opa_q;
        opb_d   = opb_q;
        res_d   = res_q;
        s_d     = s_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        carry_d = carry_q;
        ovu_d   = ovu_q;
        ovs_d   = ovs_q;

        if (accept) begin
            // Subtraction is A + ~B + 1: invert B and seed the carry with MODE.
            opa_d   = A;
            opb_d   = MODE ? ~B : B;
            mode_d  = MODE;
            carry_d = MODE;
            cnt_d   = '0;
            res_d   = '0;
        end else if (state_q == StRun) begin
            res_d   = {sum_bit, res_q[WIDTH-1:1]};
            opa_d   = opa_q >> 1;
            opb_d   = opb_q >> 1;
            carry_d = carry_nxt;
            if (!last_bit) begin
                cnt_d = cnt_q + 1'b1;
            end
            if (last_bit) begin
                s_d   = {sum_bit, res_q[WIDTH-1:1]};
                // For subtract the carry-out is the inverse of the borrow.
                ovu_d = carry_nxt ^ mode_q;
                // carry_q is the carry into the MSB at this point.
                ovs_d = carry_q ^ carry_nxt;
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opa_q   <= '0;
            opb_q   <= '0;
            res_q   <= '0;
            s_q     <= '0;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            carry_q <= 1'b0;
            ovu_q   <= 1'b0;
            ovs_q   <= 1'b0;
        end else begin
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            res_q   <= res_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            carry_q <= carry_d;
            ovu_q   <= ovu_d;
            ovs_q   <= ovs_d;
        end
    end

    assign S   = s_q;
    assign OVU = ovu_q;
    assign OVS = ovs_q;

endmodule
